// File: rtl/minmax_pkg.sv
// -----------------------------------------------------------------------------
// minmax_pkg
// Shared definitions for the min/max scan unit:
//   - comparator result codes (A==B, A>B, A<B)
//   - FSM state encoding for the scan sequencer
// -----------------------------------------------------------------------------
package minmax_pkg;

  typedef logic [7:0] operand_t;

  // Result codes produced by the shared 8-bit magnitude comparator.
  localparam operand_t CMP_EQ = 8'h00;
  localparam operand_t CMP_GT = 8'h01;
  localparam operand_t CMP_LT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CMP_MAX,
    CMP_MIN,
    DONE
  } state_t;

endpackage : minmax_pkg

// File: rtl/minmax_scanner_if.sv
// -----------------------------------------------------------------------------
// minmax_scanner_if
// Bundles the frame-control, operand stream and result signals of the
// min/max scan unit.
//   master : frame producer / result consumer (drives start, len, in_valid,
//            in_data)
//   slave  : the scanner (drives in_ready, busy, done and the four results)
// -----------------------------------------------------------------------------
interface minmax_scanner_if #(
  parameter int CNT_W = 4
);
  import minmax_pkg::*;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  operand_t         in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  operand_t         max_val;
  operand_t         min_val;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] min_idx;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, max_val, min_val, max_idx, min_idx
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, max_val, min_val, max_idx, min_idx
  );

endinterface : minmax_scanner_if

// File: rtl/minmax_scanner_cmp.sv
// -----------------------------------------------------------------------------
// minmax_scanner_cmp
// Unsigned 8-bit magnitude comparator.
//   a, b : operands
//   y    : CMP_GT when a>b, CMP_LT when a<b, CMP_EQ otherwise
// -----------------------------------------------------------------------------
module minmax_scanner_cmp
  import minmax_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output operand_t y
);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    y = CMP_EQ;
    if (a > b)      y = CMP_GT;
    else if (a < b) y = CMP_LT;
  end

endmodule : minmax_scanner_cmp

// File: rtl/minmax_scanner.sv
// -----------------------------------------------------------------------------
// minmax_scanner
// Streams a frame of up to 2^CNT_W-1 unsigned 8-bit operands through one
// shared comparator and reports the frame's maximum and minimum with the
// index of their first occurrence. Each element after the first spends one
// cycle against the running max and one against the running min.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : minmax_scanner_if slave port (start/len, in_valid/in_data/in_ready,
//         busy, done pulse, max_val/min_val, max_idx/min_idx)
// -----------------------------------------------------------------------------
module minmax_scanner
  import minmax_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  minmax_scanner_if.slave   bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  operand_t         cur;
  operand_t         max_q, min_q;
  logic [CNT_W-1:0] max_idx_q, min_idx_q;
  operand_t         cmp_b;
  operand_t         cmp_y;
  logic             xfer;

  assign xfer      = bus.in_valid && (state == FETCH);
  // len never exceeds 2^CNT_W-1, so count+1 cannot wrap.
  assign count_inc = count + CNT_W'(1);

  // The single comparator always sees the current element as A; B follows
  // the compare phase so one instance serves both the max and min passes.
  assign cmp_b = (state == CMP_MIN) ? min_q : max_q;

  minmax_scanner_cmp u_cmp (
    .a (cur),
    .b (cmp_b),
    .y (cmp_y)
  );

  // Status outputs are pure state decodes, so in_ready never depends
  // combinationally on in_valid.
  assign bus.in_ready = (state == FETCH);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.max_val  = max_q;
  assign bus.min_val  = min_q;
  assign bus.max_idx  = max_idx_q;
  assign bus.min_idx  = min_idx_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (xfer) begin
          if (count == '0) state_nxt = (len_q == CNT_W'(1)) ? DONE : FETCH;
          else             state_nxt = CMP_MAX;
        end
      end
      CMP_MAX: state_nxt = CMP_MIN;
      CMP_MIN: state_nxt = (count_inc == len_q) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      count     <= '0;
      cur       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q     <= bus.len;
            count     <= '0;
            max_q     <= 8'h00;
            min_q     <= 8'hFF;
            max_idx_q <= '0;
            min_idx_q <= '0;
          end
        end
        FETCH: begin
          if (xfer) begin
            cur <= bus.in_data;
            // First element seeds both extremes directly; no compare needed.
            if (count == '0) begin
              max_q     <= bus.in_data;
              min_q     <= bus.in_data;
              max_idx_q <= '0;
              min_idx_q <= '0;
              count     <= CNT_W'(1);
            end
          end
        end
        CMP_MAX: begin
          // Strictly greater only: ties keep the earliest index.
          if (cmp_y == CMP_GT) begin
            max_q     <= cur;
            max_idx_q <= count;
          end
        end
        CMP_MIN: begin
          if (cmp_y == CMP_LT) begin
            min_q     <= cur;
            min_idx_q <= count;
          end
          count <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule : minmax_scanner
